// File: rtl/fp_alu_seq_ctrl.sv
// Sequencer for multi-cycle FP ops on the shared ALU: issues a start pulse, holds the opcode,
// stalls the PC and gates write-back until the ALU reports done or a timeout fires.
module fp_alu_seq_ctrl #(
  parameter int CTL_W   = 5,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inst_valid,
  input  logic [CTL_W-1:0] alu_ctl,
  input  logic             fp_done,
  input  logic             fp_exception,
  input  logic             clr_exc,
  output logic             fp_start,
  output logic [CTL_W-1:0] op_ctl,
  output logic             pc_stall,
  output logic             wb_en,
  output logic             busy,
  output logic             timeout_err,
  output logic             fp_exc_sticky,
  output logic [CNT_W-1:0] fp_op_count
);

  localparam int WCNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WCNT_W-1:0] LP_WAIT_LAST = WCNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_COMMIT,
    S_ERR
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [CTL_W-1:0]   r_op_ctl;
  logic [WCNT_W-1:0]  r_wait_cnt;
  logic               r_exc_sticky;
  logic [CNT_W-1:0]   r_op_count;
  logic               w_fp_req;
  logic               w_wait_hit;

  assign w_fp_req   = inst_valid & alu_ctl[CTL_W-1];
  assign w_wait_hit = (r_wait_cnt == LP_WAIT_LAST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    fp_start    = 1'b0;
    pc_stall    = 1'b1;
    wb_en       = 1'b0;
    busy        = 1'b0;
    timeout_err = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Integer ops pass straight through; only an FP request stalls the PC.
        pc_stall = w_fp_req;
        wb_en    = ~w_fp_req;
        if (w_fp_req) begin
          w_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        fp_start = 1'b1;
        busy     = 1'b1;
        w_next   = S_WAIT;
      end
      S_WAIT: begin
        busy = 1'b1;
        // A completion on the final allowed cycle still commits.
        if (fp_done) begin
          w_next = S_COMMIT;
        end else if (w_wait_hit) begin
          w_next = S_ERR;
        end
      end
      S_COMMIT: begin
        busy     = 1'b1;
        pc_stall = 1'b0;
        wb_en    = 1'b1;
        w_next   = S_IDLE;
      end
      S_ERR: begin
        timeout_err = 1'b1;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_op_ctl     <= '0;
      r_wait_cnt   <= '0;
      r_exc_sticky <= 1'b0;
      r_op_count   <= '0;
    end else begin
      if ((r_state == S_IDLE) && w_fp_req) begin
        r_op_ctl <= alu_ctl;
      end
      if (r_state == S_ISSUE) begin
        r_wait_cnt <= '0;
      end else if ((r_state == S_WAIT) && !fp_done && !w_wait_hit) begin
        r_wait_cnt <= r_wait_cnt + WCNT_W'(1);
      end
      // Setting takes priority over a simultaneous clear so no exception is lost.
      if ((r_state == S_WAIT) && fp_done && fp_exception) begin
        r_exc_sticky <= 1'b1;
      end else if (clr_exc) begin
        r_exc_sticky <= 1'b0;
      end
      if (r_state == S_COMMIT) begin
        r_op_count <= r_op_count + CNT_W'(1);
      end
    end
  end

  assign op_ctl        = r_op_ctl;
  assign fp_exc_sticky = r_exc_sticky;
  assign fp_op_count   = r_op_count;

endmodule

// File: tb/tb_fp_alu_seq_ctrl.sv
// Directed bench for fp_alu_seq_ctrl; a second narrow-counter instance shares the inputs
// so counter wrap-around can be exercised in a few dozen operations.
module tb_fp_alu_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_valid;
  logic [4:0]  alu_ctl;
  logic        fp_done;
  logic        fp_exception;
  logic        clr_exc;

  logic        fp_start, pc_stall, wb_en, busy, timeout_err, fp_exc_sticky;
  logic [4:0]  op_ctl;
  logic [15:0] fp_op_count;

  logic        w_fp_start, w_pc_stall, w_wb_en, w_busy, w_timeout_err, w_fp_exc_sticky;
  logic [4:0]  w_op_ctl;
  logic [3:0]  w_fp_op_count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fp_alu_seq_ctrl #(.CTL_W(5), .TIMEOUT(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .inst_valid(inst_valid), .alu_ctl(alu_ctl),
    .fp_done(fp_done), .fp_exception(fp_exception), .clr_exc(clr_exc),
    .fp_start(fp_start), .op_ctl(op_ctl), .pc_stall(pc_stall), .wb_en(wb_en),
    .busy(busy), .timeout_err(timeout_err), .fp_exc_sticky(fp_exc_sticky),
    .fp_op_count(fp_op_count)
  );

  fp_alu_seq_ctrl #(.CTL_W(5), .TIMEOUT(8), .CNT_W(4)) dut_w (
    .clk(clk), .rst(rst), .inst_valid(inst_valid), .alu_ctl(alu_ctl),
    .fp_done(fp_done), .fp_exception(fp_exception), .clr_exc(clr_exc),
    .fp_start(w_fp_start), .op_ctl(w_op_ctl), .pc_stall(w_pc_stall), .wb_en(w_wb_en),
    .busy(w_busy), .timeout_err(w_timeout_err), .fp_exc_sticky(w_fp_exc_sticky),
    .fp_op_count(w_fp_op_count)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  // One FP op from IDLE with done on the n-th WAIT cycle; returns one cycle after COMMIT.
  task automatic run_op(input int n, input logic exc, input logic clr);
    inst_valid = 1'b1;
    alu_ctl    = 5'b10011;
    fp_done    = 1'b0;
    tick();
    tick();
    for (int i = 1; i < n; i++) tick();
    fp_done      = 1'b1;
    fp_exception = exc;
    clr_exc      = clr;
    tick();
    fp_done      = 1'b0;
    fp_exception = 1'b0;
    clr_exc      = 1'b0;
    inst_valid   = 1'b0;
    settle();
    check("commit_wb", {31'd0, wb_en}, 32'd1);
    tick();
    settle();
    check("op_back_idle", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    rst = 1'b0; inst_valid = 1'b0; alu_ctl = 5'd0;
    fp_done = 1'b0; fp_exception = 1'b0; clr_exc = 1'b0;
    do_reset();
    settle();
    check("rst_op_ctl", {27'd0, op_ctl}, 32'd0);
    check("rst_fp_start", {31'd0, fp_start}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_timeout", {31'd0, timeout_err}, 32'd0);
    check("rst_exc", {31'd0, fp_exc_sticky}, 32'd0);
    check("rst_count", {16'd0, fp_op_count}, 32'd0);
    check("rst_stall", {31'd0, pc_stall}, 32'd0);
    check("rst_wb", {31'd0, wb_en}, 32'd1);

    // Integer op: no overhead.
    inst_valid = 1'b1;
    alu_ctl    = 5'b00010;
    for (int i = 0; i < 4; i++) begin
      settle();
      check("int_stall", {31'd0, pc_stall}, 32'd0);
      check("int_wb", {31'd0, wb_en}, 32'd1);
      check("int_start", {31'd0, fp_start}, 32'd0);
      tick();
    end
    check("int_count", {16'd0, fp_op_count}, 32'd0);

    // FP op, done on 3rd WAIT cycle.
    alu_ctl = 5'b10011;
    settle();
    check("fp_idle_stall", {31'd0, pc_stall}, 32'd1);
    check("fp_idle_wb", {31'd0, wb_en}, 32'd0);
    check("fp_idle_start", {31'd0, fp_start}, 32'd0);
    tick();
    check("fp_issue_start", {31'd0, fp_start}, 32'd1);
    check("fp_issue_stall", {31'd0, pc_stall}, 32'd1);
    check("fp_issue_wb", {31'd0, wb_en}, 32'd0);
    check("fp_issue_opctl", {27'd0, op_ctl}, 32'h13);
    for (int i = 1; i <= 3; i++) begin
      tick();
      if (i == 3) fp_done = 1'b1;
      settle();
      check("fp_wait_start", {31'd0, fp_start}, 32'd0);
      check("fp_wait_stall", {31'd0, pc_stall}, 32'd1);
      check("fp_wait_wb", {31'd0, wb_en}, 32'd0);
      check("fp_wait_busy", {31'd0, busy}, 32'd1);
    end
    tick();
    fp_done    = 1'b0;
    inst_valid = 1'b0;
    settle();
    check("fp_commit_stall", {31'd0, pc_stall}, 32'd0);
    check("fp_commit_wb", {31'd0, wb_en}, 32'd1);
    check("fp_commit_opctl", {27'd0, op_ctl}, 32'h13);
    check("fp_commit_busy", {31'd0, busy}, 32'd1);
    tick();
    check("fp_count", {16'd0, fp_op_count}, 32'd1);
    check("fp_after_busy", {31'd0, busy}, 32'd0);

    // Timeout: no done ever.
    do_reset();
    inst_valid = 1'b1;
    alu_ctl    = 5'b10101;
    tick();
    tick();
    for (int i = 1; i < 8; i++) tick();
    check("to_wait8_err", {31'd0, timeout_err}, 32'd0);
    check("to_wait8_busy", {31'd0, busy}, 32'd1);
    tick();
    for (int i = 0; i < 50; i++) begin
      fp_done = (i == 3);
      settle();
      check("to_err_flag", {31'd0, timeout_err}, 32'd1);
      check("to_err_stall", {31'd0, pc_stall}, 32'd1);
      check("to_err_wb", {31'd0, wb_en}, 32'd0);
      tick();
    end
    fp_done = 1'b0;
    check("to_err_count", {16'd0, fp_op_count}, 32'd0);
    inst_valid = 1'b0;
    do_reset();
    settle();
    check("to_rst_clear", {31'd0, timeout_err}, 32'd0);

    // Done on the 8th (last) WAIT cycle wins over timeout.
    run_op(8, 1'b0, 1'b0);
    check("late_done_err", {31'd0, timeout_err}, 32'd0);
    check("late_done_count", {16'd0, fp_op_count}, 32'd1);

    // Reset during 2nd WAIT cycle, done arrives afterwards.
    inst_valid = 1'b1;
    alu_ctl    = 5'b10001;
    tick();
    tick();
    tick();
    check("abort_in_wait", {31'd0, busy}, 32'd1);
    rst        = 1'b0;
    inst_valid = 1'b0;
    tick();
    rst     = 1'b1;
    fp_done = 1'b1;
    settle();
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_opctl", {27'd0, op_ctl}, 32'd0);
    check("abort_count", {16'd0, fp_op_count}, 32'd0);
    check("abort_stall", {31'd0, pc_stall}, 32'd0);
    tick();
    fp_done = 1'b0;
    settle();
    check("abort_after_busy", {31'd0, busy}, 32'd0);
    check("abort_after_count", {16'd0, fp_op_count}, 32'd0);
    check("abort_after_start", {31'd0, fp_start}, 32'd0);

    // Exception set and clear in same cycle: set wins; clear alone later.
    run_op(1, 1'b1, 1'b1);
    check("exc_set_wins", {31'd0, fp_exc_sticky}, 32'd1);
    clr_exc = 1'b1;
    tick();
    clr_exc = 1'b0;
    check("exc_cleared", {31'd0, fp_exc_sticky}, 32'd0);

    // Counter wrap on the narrow-counter instance.
    do_reset();
    for (int i = 0; i < 15; i++) run_op(1, 1'b0, 1'b0);
    check("wrap_pre", {28'd0, w_fp_op_count}, 32'd15);
    run_op(2, 1'b0, 1'b0);
    check("wrap_zero", {28'd0, w_fp_op_count}, 32'd0);
    check("wide_count", {16'd0, fp_op_count}, 32'd16);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
